// File: rtl/code_pkg.sv
// rtl/code_pkg.sv - shared types and widths for the code decoder
package code_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        onehot = ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// rtl/code_fifo.sv - code FIFO with occupancy count; pushes while full are ignored
module code_fifo
    import code_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [CODE_W-1:0]        din,
    output logic [CODE_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [LW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/code_decoder.sv
// rtl/code_decoder.sv - queued binary-to-one-hot display; CODE_DECODER_MASK_EN adds sticky Mask output
module code_decoder
    import code_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   EN,
    input  logic                   Done,
    input  logic [CODE_W-1:0]      Y,
    output logic                   Ready,
    output logic [ONEHOT_W-1:0]    Out,
    output logic                   Valid,
    output logic [$clog2(DEPTH):0] Level
`ifdef CODE_DECODER_MASK_EN
    ,
    output logic [ONEHOT_W-1:0]    Mask
`endif
);

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [ONEHOT_W-1:0] out_n;
    logic                push, pop;
    logic                full, empty;
    logic [CODE_W-1:0]   head;

    assign Ready = !full && !rst;
    assign push  = EN && Done && Ready;
    assign Valid = |Out;

    code_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (Y),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (Level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            Out   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            Out   <= out_n;
        end
    end

    // A code with an expired hold is replaced in the same cycle, so no blank gap appears.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = Out;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                out_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    out_n   = onehot(head);
                    cnt_n   = HOLD_M1;
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 4'd1;
                end else if (!empty) begin
                    pop   = 1'b1;
                    out_n = onehot(head);
                    cnt_n = HOLD_M1;
                end else begin
                    out_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                out_n   = '0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

`ifdef CODE_DECODER_MASK_EN
    always_ff @(posedge clk) begin
        if (rst)      Mask <= '0;
        else if (pop) Mask <= Mask | onehot(head);
    end
`endif

endmodule

// File: tb/tb_code_decoder.sv
// tb/tb_code_decoder.sv - scoreboard bench for code_decoder
module tb_code_decoder;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       EN;
    logic       Done;
    logic [2:0] Y;
    logic       Ready;
    logic [7:0] Out;
    logic       Valid;
    logic [2:0] Level;
`ifdef CODE_DECODER_MASK_EN
    logic [7:0] Mask;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] expq[$];
    logic [7:0] e;
    bit         prev_valid;

    always #5 clk = ~clk;

    code_decoder #(.DEPTH(4), .HOLD(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .EN    (EN),
        .Done  (Done),
        .Y     (Y),
        .Ready (Ready),
        .Out   (Out),
        .Valid (Valid),
        .Level (Level)
`ifdef CODE_DECODER_MASK_EN
        ,
        .Mask  (Mask)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] y, input bit acc);
        logic [7:0] one;
        one  = 8'h01;
        EN   = 1'b1;
        Done = 1'b1;
        Y    = y;
        if (acc) repeat (HOLD) expq.push_back(one << y);
        @(negedge clk);
    endtask

    task automatic idle();
        EN   = 1'b0;
        Done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (expq.size() == 0 && !Valid) break;
            @(negedge clk);
        end
        check(name, (expq.size() == 0 && !Valid), 1);
        check({name, "_level"}, Level, 0);
    endtask

    // Monitor: every displayed cycle consumes one expected Out value.
    initial begin
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                check("onehot_valid", ($onehot0(Out) && (Valid == (Out != 0))), 1);
                if (Valid) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_display: got %0h expected none", Out);
                    end else begin
                        e = expq.pop_front();
                        check("out", Out, e);
                    end
                end else if (prev_valid && expq.size() != 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL gap: got Valid=0 expected Valid=1");
                end
                prev_valid = Valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        EN   = 1'b0;
        Done = 1'b0;
        Y    = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", Ready, 1);
        check("rst_out", Out, 0);
        check("rst_valid", Valid, 0);
        check("rst_level", Level, 0);
        @(negedge clk);

        // Single code: one-edge latency, HOLD cycles on Out.
        drive(3'd3, 1'b1);
        idle();
        check("lat_valid0", Valid, 0);
        check("lat_level1", Level, 1);
        @(negedge clk);
        check("lat_out", Out, 8'h08);
        check("lat_level0", Level, 0);
        wait_drain("single");

        // Back-to-back codes, no gap, level peaks at 2.
        drive(3'd0, 1'b1);
        drive(3'd7, 1'b1);
        drive(3'd5, 1'b1);
        idle();
        check("b2b_level", Level, 2);
        wait_drain("b2b");

        // Overfill: fifth push fills, sixth is dropped.
        drive(3'd1, 1'b1);
        drive(3'd2, 1'b1);
        drive(3'd3, 1'b1);
        drive(3'd4, 1'b1);
        drive(3'd5, 1'b1);
        check("full_level", Level, 4);
        check("full_ready", Ready, 0);
        drive(3'd6, 1'b0);
        idle();
        check("full_level_after", Level, 3);
        wait_drain("full");

        // EN low blocks pushes.
        EN   = 1'b0;
        Done = 1'b1;
        Y    = 3'd2;
        repeat (3) @(negedge clk);
        check("en0_level", Level, 0);
        check("en0_out", Out, 0);

        // EN low still drains queued codes.
        drive(3'd2, 1'b1);
        drive(3'd3, 1'b1);
        drive(3'd4, 1'b1);
        EN   = 1'b0;
        Done = 1'b1;
        Y    = 3'd7;
        check("en0_queued", Level, 2);
        wait_drain("en0_drain");
        idle();

        // Reset mid-SHOW with three queued; push attempt on the reset edge.
        drive(3'd1, 1'b1);
        drive(3'd2, 1'b1);
        drive(3'd3, 1'b1);
        drive(3'd4, 1'b1);
        check("mid_level3", Level, 3);
        rst = 1'b1;
        Y   = 3'd5;
        expq.delete();
        @(negedge clk);
        check("mid_out", Out, 0);
        check("mid_valid", Valid, 0);
        check("mid_level", Level, 0);
        check("mid_ready_inrst", Ready, 0);
        rst = 1'b0;
        idle();
        #1;
        check("mid_ready", Ready, 1);
        @(negedge clk);
        check("mid_out2", Out, 0);
        check("mid_level2", Level, 0);

`ifdef CODE_DECODER_MASK_EN
        drive(3'd1, 1'b1);
        drive(3'd4, 1'b1);
        idle();
        wait_drain("mask_drain");
        check("mask_set", Mask, 8'h12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mask_clr", Mask, 8'h00);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
